// File: rtl/io_wbuf_pkg.sv
// Shared constants and the queued-entry layout for the io_wbuf shim.
package io_wbuf_pkg;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam int          IO_HI   = 17;
  localparam int          IO_LO   = 16;
  localparam logic [1:0]  IO_SEL  = 2'b11;
  localparam int          ENTRY_W = 11;

  typedef struct packed {
    logic [2:0] off;
    logic [7:0] dat;
  } entry_t;
endpackage

// File: rtl/io_wbuf_fifo.sv
// Synchronous DEPTH x ENTRY_W FIFO; head is visible combinationally, push/pop take effect at the edge.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module io_wbuf_fifo
  import io_wbuf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  entry_t           din,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W + 1)'(1);
      else if (do_pop && !do_push) count <= count - (PTR_W + 1)'(1);
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/io_wbuf.sv
// Core/RAM bus shim buffering IO-region writes and draining them one byte per stolen cycle.
// IOBUF_STAT_EN adds hold-cycle and peak-occupancy counters on stat_o; otherwise stat_o is 0.
module io_wbuf
  import io_wbuf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        cpu_en,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  input  logic [7:0]  mem_din,
  input  logic        io_buffer_full,
  output logic [31:0] stat_o
);
  entry_t           head;
  entry_t           new_entry;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   count;
  logic             act;
  logic             io_hit;
  logic             drain;
  logic             hold;
  logic             push;
  logic             own_q;
  logic [7:0]       rd_hold;

  assign act       = en & ~rst;
  assign io_hit    = (cpu_a[IO_HI:IO_LO] == IO_SEL);
  assign drain     = act & ~empty & ~io_buffer_full;
  // IO reads wait for the queue to empty so they never overtake buffered writes.
  assign hold      = io_hit & ((cpu_wr & full) | (~cpu_wr & ~empty));
  assign cpu_en    = act & ~drain & ~hold;
  assign push      = cpu_en & cpu_wr & io_hit;
  assign new_entry = '{off: cpu_a[2:0], dat: cpu_dout};

  io_wbuf_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (drain),
    .din   (new_entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    mem_a    = cpu_a;
    mem_dout = cpu_dout;
    mem_wr   = act & cpu_wr & ~io_hit;
    if (drain) begin
      mem_a    = IO_BASE | 32'(head.off);
      mem_dout = head.dat;
      mem_wr   = 1'b1;
    end
  end

  // Read data arrives the cycle after the address; park it if that cycle gets stolen.
  always_ff @(posedge clk) begin
    if (rst) begin
      own_q   <= 1'b1;
      rd_hold <= 8'h00;
    end else if (en) begin
      own_q <= ~drain;
      if (own_q) rd_hold <= mem_din;
    end
  end

  assign cpu_din = own_q ? mem_din : rd_hold;

`ifdef IOBUF_STAT_EN
  logic [15:0] hold_cnt;
  logic [7:0]  peak;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 16'h0000;
      peak     <= 8'h00;
    end else if (en) begin
      if (hold && hold_cnt != 16'hFFFF) hold_cnt <= hold_cnt + 16'h0001;
      if (8'(count) > peak) peak <= 8'(count);
    end
  end

  assign stat_o = rst ? 32'h0 : {hold_cnt, 8'h00, peak};
`else
  logic unused_count;
  assign unused_count = ^count;
  assign stat_o       = 32'h0;
`endif
endmodule

// File: tb/tb_io_wbuf.sv
// Directed bench for io_wbuf: pass-through, buffering, full stall, ordered IO read, stolen-cycle read, reset.
`timescale 1ns/1ps
module tb_io_wbuf;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        cpu_en;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [31:0] stat_o;

  int total = 0;
  int bad   = 0;

  io_wbuf #(.DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .cpu_a          (cpu_a),
    .cpu_dout       (cpu_dout),
    .cpu_wr         (cpu_wr),
    .cpu_din        (cpu_din),
    .cpu_en         (cpu_en),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .stat_o         (stat_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then leave time for new inputs to be driven and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [7:0] d, input logic wr);
    cpu_a    = a;
    cpu_dout = d;
    cpu_wr   = wr;
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; io_buffer_full = 1'b0; mem_din = 8'h00;
    #1;
    drive(32'h100, 8'h11, 1'b1);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_stat", stat_o, 32'h0);
    step(); step();
    rst = 1'b0;
    drive(32'h10, 8'h00, 1'b0);
    chk("post_rst_count", 32'(dut.u_fifo.count), 32'd0);

    // Plain RAM read
    chk("rd_cpu_en0", 32'(cpu_en), 32'd1);
    chk("rd_mem_wr", 32'(mem_wr), 32'd0);
    chk("rd_mem_a", mem_a, 32'h10);
    step();
    mem_din = 8'hA5; #1;
    chk("rd_cpu_din", 32'(cpu_din), 32'hA5);
    chk("rd_cpu_en1", 32'(cpu_en), 32'd1);

    // Two buffered writes while UART is full, then drain
    io_buffer_full = 1'b1;
    drive(32'h30000, 8'h48, 1'b1);
    chk("h_cpu_en", 32'(cpu_en), 32'd1);
    chk("h_mem_wr", 32'(mem_wr), 32'd0);
    step();
    drive(32'h30000, 8'h69, 1'b1);
    chk("i_mem_wr", 32'(mem_wr), 32'd0);
    step();
    drive(32'h100, 8'h00, 1'b0);
    chk("hi_count", 32'(dut.u_fifo.count), 32'd2);
    io_buffer_full = 1'b0; #1;
    chk("d0_mem_a", mem_a, 32'h30000);
    chk("d0_mem_dout", 32'(mem_dout), 32'h48);
    chk("d0_mem_wr", 32'(mem_wr), 32'd1);
    chk("d0_cpu_en", 32'(cpu_en), 32'd0);
    step();
    chk("d1_mem_a", mem_a, 32'h30000);
    chk("d1_mem_dout", 32'(mem_dout), 32'h69);
    chk("d1_cpu_en", 32'(cpu_en), 32'd0);
    step();
    chk("hi_empty", 32'(dut.u_fifo.count), 32'd0);
    chk("hi_cpu_en", 32'(cpu_en), 32'd1);

    // Fill to DEPTH, stall the ninth write, keep non-IO traffic moving
    io_buffer_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(32'h30000 + 32'(i % 8), 8'(i), 1'b1);
      chk($sformatf("fill_cpu_en%0d", i), 32'(cpu_en), 32'd1);
      step();
    end
    drive(32'h200, 8'h00, 1'b0);
    chk("full_ram_cpu_en", 32'(cpu_en), 32'd1);
    chk("full_ram_mem_a", mem_a, 32'h200);
    step();
    drive(32'h30000, 8'h08, 1'b1);
    chk("full_count", 32'(dut.u_fifo.count), 32'd8);
    chk("full_stall", 32'(cpu_en), 32'd0);
    chk("full_stall_wr", 32'(mem_wr), 32'd0);
    step();
    chk("full_count_hold", 32'(dut.u_fifo.count), 32'd8);
    io_buffer_full = 1'b0; #1;
    chk("pop1_mem_a", mem_a, 32'h30000);
    chk("pop1_mem_dout", 32'(mem_dout), 32'h00);
    chk("pop1_cpu_en", 32'(cpu_en), 32'd0);
    step();
    io_buffer_full = 1'b1; #1;
    chk("pop1_count", 32'(dut.u_fifo.count), 32'd7);
    chk("ninth_cpu_en", 32'(cpu_en), 32'd1);
    step();
    chk("ninth_count", 32'(dut.u_fifo.count), 32'd8);
`ifdef IOBUF_STAT_EN
    chk("stat_peak", 32'(stat_o[7:0]), 32'd8);
`endif
    drive(32'h100, 8'h00, 1'b0);
    io_buffer_full = 1'b0; #1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("wrap_mem_a%0d", k), mem_a, 32'h30000 + 32'(k % 8));
      chk($sformatf("wrap_mem_dout%0d", k), 32'(mem_dout), 32'(k));
      step();
    end
    chk("wrap_empty", 32'(dut.u_fifo.count), 32'd0);

    // IO read waits behind a queued write
    io_buffer_full = 1'b1;
    drive(32'h30001, 8'h77, 1'b1);
    step();
    drive(32'h30004, 8'h00, 1'b0);
    chk("ior_stall", 32'(cpu_en), 32'd0);
    chk("ior_stall_wr", 32'(mem_wr), 32'd0);
    step();
    io_buffer_full = 1'b0; #1;
    chk("ior_drain_a", mem_a, 32'h30001);
    chk("ior_drain_dout", 32'(mem_dout), 32'h77);
    chk("ior_drain_cpu_en", 32'(cpu_en), 32'd0);
    step();
    chk("ior_pass_cpu_en", 32'(cpu_en), 32'd1);
    chk("ior_pass_a", mem_a, 32'h30004);
    chk("ior_pass_wr", 32'(mem_wr), 32'd0);
    step();

    // RAM read whose data cycle is stolen by a drain
    io_buffer_full = 1'b1;
    drive(32'h30002, 8'h55, 1'b1);
    step();
    drive(32'h100, 8'h00, 1'b0);
    chk("steal_rd_cpu_en", 32'(cpu_en), 32'd1);
    step();
    io_buffer_full = 1'b0; mem_din = 8'h3C; #1;
    chk("steal_cpu_en", 32'(cpu_en), 32'd0);
    chk("steal_mem_wr", 32'(mem_wr), 32'd1);
    chk("steal_mem_dout", 32'(mem_dout), 32'h55);
    step();
    mem_din = 8'hEE; #1;
    chk("resume_cpu_en", 32'(cpu_en), 32'd1);
    chk("resume_cpu_din", 32'(cpu_din), 32'h3C);

    // Freeze with en low, then reset with entries queued
    io_buffer_full = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(32'h30003, 8'(i), 1'b1);
      step();
    end
    drive(32'h100, 8'h00, 1'b0);
    en = 1'b0; io_buffer_full = 1'b0; #1;
    chk("en0_mem_wr", 32'(mem_wr), 32'd0);
    chk("en0_cpu_en", 32'(cpu_en), 32'd0);
    step();
    chk("en0_count", 32'(dut.u_fifo.count), 32'd3);
    en = 1'b1; rst = 1'b1; #1;
    chk("rst2_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst2_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst2_stat", stat_o, 32'h0);
    step();
    rst = 1'b0; #1;
    chk("rst2_count", 32'(dut.u_fifo.count), 32'd0);
    chk("rst2_after_wr", 32'(mem_wr), 32'd0);
    chk("rst2_after_en", 32'(cpu_en), 32'd1);
    step();
    chk("rst2_no_drain", 32'(mem_wr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/io_wbuf.md
# io_wbuf

Memory-port shim between the CPU core's byte bus (mem_din/mem_dout/mem_a/mem_wr) and the RAM/UART side. It buffers I/O writes (mem_a[17:16]==2'b11) in a small FIFO so the core is not blocked while the UART reports io_buffer_full. It drains those writes in order, stealing one bus cycle per byte. It gates the core's enable and keeps read data coherent across stolen cycles.

## Interface
Parameters:
- DEPTH, 8, FIFO entries (power of two, ≥2)
- PTR_W, $clog2(DEPTH), FIFO pointer width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; block state frozen when low
- cpu_a  in  32  core address
- cpu_dout  in  8  core write data
- cpu_wr  in  1  core write strobe (1 = write)
- cpu_din  out  8  read data to core
- cpu_en  out  1  enable to core (core advances only when high)
- mem_a  out  32  address to RAM/IO
- mem_dout  out  8  write data to RAM/IO
- mem_wr  out  1  write strobe to RAM/IO
- mem_din  in  8  RAM/IO read data (valid cycle after the address)
- io_buffer_full  in  1  UART TX buffer full
- stat_o  out  32  statistics (IOBUF_STAT_EN only, else tied 0)

## Operation
- io_hit = (cpu_a[17:16]==2'b11). Entry = {cpu_a[2:0], cpu_dout} (11 bits).
- drain = en & !empty & !io_buffer_full. Drain has priority over the core.
- Drain cycle: mem_a = 32'h30000 | head offset, mem_dout = head data, mem_wr = 1, cpu_en = 0; pop at edge.
- Otherwise bus is pass-through: mem_a = cpu_a, mem_dout = cpu_dout, mem_wr = cpu_wr & !io_hit.
- hold = io_hit & ((cpu_wr & full) | (!cpu_wr & !empty)). IO reads wait until FIFO empty, which preserves order.
- cpu_en = en & !drain & !hold.
- Push when cpu_en & cpu_wr & io_hit. The core's write is accepted at that edge.
- Non-IO accesses pass straight through whenever cpu_en=1.
- Ownership flag own_q: registered 1 if the cycle was core-owned (!drain).
- Read data: rd_hold captures mem_din every cycle where own_q=1.
- cpu_din = own_q ? mem_din : rd_hold. A core read followed by a stolen cycle still returns its data.
- Push and pop in the same cycle are not possible (drain forces cpu_en=0).
- Count is unchanged except by a single push or a single pop.
- en low: no push, no pop, mem_wr = 0, cpu_en = 0, registers hold.

## Timing
- Reset values: count=0, pointers=0, own_q=1, rd_hold=0, stat counters 0.
- During rst: mem_wr=0, cpu_en=0, stat_o=0.
- Pass-through path is combinational, with zero added latency on non-IO accesses.
- Pushed at edge N, an entry can drain earliest in cycle N+1.
- A full FIFO with io_buffer_full held: the core stalls on further IO writes until a pop. Non-IO traffic continues.
- Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- Reset mid-drain discards all queued entries. No partial write is emitted after rst.

## Configuration
- IOBUF_STAT_EN defined: stat_o = {16-bit saturating count of hold cycles, 8'b0, 8-bit peak occupancy}. Both clear on rst.
- IOBUF_STAT_EN undefined: counters absent, stat_o = 32'b0.

## Structure
- Shared header holds IO_BASE (32'h30000), the IO-region decode bits [17:16], and the entry width constant.
- One sub-module, io_wbuf_fifo: synchronous DEPTH×11 FIFO with push/pop, full/empty, count.
- Decode, arbitration, read-data hold and stats live in io_wbuf.

## Test plan
- Reset, then a core read of 0x00010 with mem_din=8'hA5 the next cycle. Expect cpu_din=8'hA5, cpu_en=1 throughout, mem_wr=0.
- io_buffer_full=1, core writes 'H','i' to 0x30000. Expect count=2, no mem_wr; release full → two drain cycles with mem_a=0x30000, mem_dout=0x48 then 0x69, cpu_en=0 in each.
- io_buffer_full=1, DEPTH+1 IO writes. Expect count=DEPTH, cpu_en=0 on the 9th. Drop full → one pop, then the 9th write is accepted.
- FIFO holding 1 entry, core reads 0x30004. Expect cpu_en=0 until drained, then the read passes with mem_a=0x30004.
- Core reads RAM 0x100 (mem_din=8'h3C next cycle) and a drain steals that next cycle. Expect cpu_din=8'h3C when the core resumes.
- Assert rst with 3 entries queued. Expect count=0, mem_wr=0 after the edge, and no further drains. IOBUF_STAT_EN build: stat_o=0.
